// File: rtl/image_buffer.sv
// image_buffer
//   Captures a square grayscale image through a valid/ready pixel port. The
//   block stores it and serves it as signed fixed-point words on an
//   asynchronous read port. It also sequences the clear / load / commit /
//   lock / release hand-off with the network.
//
// Ports
//   clk, resetn        clock; synchronous active-low reset (enters CLEARING)
//   clear              zero the whole buffer (deferred while LOCKED)
//   pix_valid/ready    pixel write handshake; ready only in IDLE
//   pix_x, pix_y       pixel column/row; out-of-range writes set dropped
//   pix_val            8-bit unsigned intensity
//   commit             hand the image to the network (IDLE only)
//   nn_start           one-cycle start pulse to the network
//   nn_done            network finished pulse; releases LOCKED
//   read_addr/data     combinational read, pix_val << FRAC_BITS, 0 if out of range
//   busy, locked       state decodes for CLEARING / LOCKED
//   write_count        accepted in-range writes since last clear, saturating
//   dropped            sticky out-of-range write flag
module image_buffer #(
  parameter int IMG_W     = 28,
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [4:0]  pix_x,
  input  logic [4:0]  pix_y,
  input  logic [7:0]  pix_val,
  input  logic        commit,
  output logic        nn_start,
  input  logic        nn_done,
  input  logic [15:0] read_addr,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        locked,
  output logic [9:0]  write_count,
  output logic        dropped
);

  localparam int          DEPTH   = IMG_W * IMG_W;
  localparam logic [9:0]  LAST    = 10'(DEPTH - 1);
  localparam logic [4:0]  IMG_W5  = 5'(IMG_W);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEARING,
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] clr_cnt_q, clr_cnt_d;
  logic       clear_pending_q, clear_pending_d;
  logic [9:0] write_count_q, write_count_d;
  logic       dropped_q, dropped_d;
  logic       nn_start_q, nn_start_d;

  // Only the 8-bit intensity is stored; the fixed-point shift is applied on read.
  logic [7:0] mem_q [DEPTH];
  logic       mem_we;
  logic [9:0] mem_waddr;
  logic [7:0] mem_wdata;

  logic [9:0] pix_addr;
  logic       pix_in_range;
  logic [7:0] rd_pix;

  assign pix_addr     = 10'(pix_y) * 10'(IMG_W) + 10'(pix_x);
  assign pix_in_range = (pix_x < IMG_W5) && (pix_y < IMG_W5);

  always_comb begin
    state_d         = state_q;
    clr_cnt_d       = clr_cnt_q;
    clear_pending_d = clear_pending_q;
    write_count_d   = write_count_q;
    dropped_d       = dropped_q;
    nn_start_d      = 1'b0;
    mem_we          = 1'b0;
    mem_waddr       = clr_cnt_q;
    mem_wdata       = '0;
    case (state_q)
      ST_CLEARING: begin
        mem_we = 1'b1;
        if (clr_cnt_q == LAST) begin
          state_d       = ST_IDLE;
          clr_cnt_d     = '0;
          write_count_d = '0;
          dropped_d     = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + 10'd1;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          // Clear wins over a same-cycle write or commit.
          state_d   = ST_CLEARING;
          clr_cnt_d = '0;
        end else begin
          if (pix_valid) begin
            if (pix_in_range) begin
              mem_we    = 1'b1;
              mem_waddr = pix_addr;
              mem_wdata = pix_val;
              if (write_count_q != '1) write_count_d = write_count_q + 10'd1;
            end else begin
              dropped_d = 1'b1;
            end
          end
          if (commit) begin
            state_d    = ST_LOCKED;
            nn_start_d = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (clear) clear_pending_d = 1'b1;
        if (nn_done) begin
          clear_pending_d = 1'b0;
          clr_cnt_d       = '0;
          state_d         = (clear_pending_q || clear) ? ST_CLEARING : ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_CLEARING;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= ST_CLEARING;
      clr_cnt_q       <= '0;
      clear_pending_q <= 1'b0;
      write_count_q   <= '0;
      dropped_q       <= 1'b0;
      nn_start_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      clear_pending_q <= clear_pending_d;
      write_count_q   <= write_count_d;
      dropped_q       <= dropped_d;
      nn_start_q      <= nn_start_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_pix    = (read_addr < DEPTH16) ? mem_q[read_addr[9:0]] : '0;
  assign read_data = 32'(rd_pix) << FRAC_BITS;

  assign pix_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_CLEARING);
  assign locked      = (state_q == ST_LOCKED);
  assign nn_start    = nn_start_q;
  assign write_count = write_count_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_image_buffer.sv
module tb_image_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        clear;
  logic        pix_valid;
  logic        pix_ready;
  logic [4:0]  pix_x;
  logic [4:0]  pix_y;
  logic [7:0]  pix_val;
  logic        commit;
  logic        nn_start;
  logic        nn_done;
  logic [15:0] read_addr;
  logic [31:0] read_data;
  logic        busy;
  logic        locked;
  logic [9:0]  write_count;
  logic        dropped;

  int n_tests = 0;
  int n_fail  = 0;
  int n_busy;

  image_buffer #(.IMG_W(28), .FRAC_BITS(8)) dut (
    .clk(clk), .resetn(resetn), .clear(clear),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_val(pix_val),
    .commit(commit), .nn_start(nn_start), .nn_done(nn_done),
    .read_addr(read_addr), .read_data(read_data),
    .busy(busy), .locked(locked),
    .write_count(write_count), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one active edge; return 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles spent in CLEARING, bounded.
  task automatic wait_clear(output int n);
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    read_addr = a;
    #1;
    check(tag, read_data, exp);
  endtask

  initial begin
    resetn = 1'b0; clear = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    pix_val = '0; commit = 1'b0; nn_done = 1'b0; read_addr = '0;

    // Reset for two cycles
    step(); step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_nn_start", 32'(nn_start), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_wcount", 32'(write_count), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    resetn = 1'b1;
    wait_clear(n_busy);
    check("rst_clear_len", 32'(n_busy), 32'd784);
    check("rst_ready_after", 32'(pix_ready), 32'd1);
    rd("rd_0", 16'd0, 32'd0);
    rd("rd_783", 16'd783, 32'd0);
    rd("rd_900", 16'd900, 32'd0);

    // Single write (3,2)=200 -> addr 59, 200*256
    pix_valid = 1'b1; pix_x = 5'd3; pix_y = 5'd2; pix_val = 8'd200;
    step();
    pix_valid = 1'b0;
    rd("wr_rd59", 16'd59, 32'h0000C800);
    check("wr_wcount", 32'(write_count), 32'd1);

    // Out-of-range write
    pix_valid = 1'b1; pix_x = 5'd28; pix_y = 5'd0; pix_val = 8'd5;
    #1 check("oor_ready", 32'(pix_ready), 32'd1);
    step();
    pix_valid = 1'b0;
    check("oor_dropped", 32'(dropped), 32'd1);
    check("oor_wcount", 32'(write_count), 32'd1);
    rd("oor_rd28", 16'd28, 32'd0);

    // Commit / lock with a held write
    commit = 1'b1;
    step();
    commit = 1'b0;
    check("cm_nn_start", 32'(nn_start), 32'd1);
    check("cm_locked", 32'(locked), 32'd1);
    check("cm_ready", 32'(pix_ready), 32'd0);
    pix_valid = 1'b1; pix_x = 5'd0; pix_y = 5'd0; pix_val = 8'd9;
    step();
    check("cm_nn_start_low", 32'(nn_start), 32'd0);
    rd("cm_rd0_frozen", 16'd0, 32'd0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    check("cm_repeat_no_start", 32'(nn_start), 32'd0);
    check("cm_still_locked", 32'(locked), 32'd1);
    nn_done = 1'b1;
    step();
    nn_done = 1'b0;
    check("rel_ready", 32'(pix_ready), 32'd1);
    check("rel_unlocked", 32'(locked), 32'd0);
    step();
    pix_valid = 1'b0;
    rd("rel_rd0", 16'd0, 32'd2304);
    check("rel_wcount", 32'(write_count), 32'd2);

    // Deferred clear
    commit = 1'b1;
    step();
    commit = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    check("dc_still_locked", 32'(locked), 32'd1);
    check("dc_not_busy", 32'(busy), 32'd0);
    nn_done = 1'b1;
    step();
    nn_done = 1'b0;
    check("dc_busy", 32'(busy), 32'd1);
    wait_clear(n_busy);
    check("dc_clear_len", 32'(n_busy), 32'd784);
    rd("dc_rd59", 16'd59, 32'd0);
    check("dc_wcount", 32'(write_count), 32'd0);
    check("dc_dropped", 32'(dropped), 32'd0);

    // nn_done outside LOCKED is ignored
    nn_done = 1'b1;
    step();
    nn_done = 1'b0;
    check("done_idle_ready", 32'(pix_ready), 32'd1);

    // clear + commit + write together: clear wins
    clear = 1'b1; commit = 1'b1;
    pix_valid = 1'b1; pix_x = 5'd1; pix_y = 5'd1; pix_val = 8'd7;
    step();
    clear = 1'b0; commit = 1'b0; pix_valid = 1'b0;
    check("cc_nn_start", 32'(nn_start), 32'd0);
    check("cc_busy", 32'(busy), 32'd1);
    check("cc_locked", 32'(locked), 32'd0);
    wait_clear(n_busy);
    check("cc_clear_len", 32'(n_busy), 32'd784);
    check("cc_wcount", 32'(write_count), 32'd0);

    // write (27,27,255) + commit
    pix_valid = 1'b1; pix_x = 5'd27; pix_y = 5'd27; pix_val = 8'd255; commit = 1'b1;
    step();
    pix_valid = 1'b0; commit = 1'b0;
    rd("wc_rd783", 16'd783, 32'd65280);
    check("wc_locked", 32'(locked), 32'd1);
    check("wc_nn_start", 32'(nn_start), 32'd1);
    check("wc_wcount", 32'(write_count), 32'd1);

    // Reset mid-inference
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("mr_busy", 32'(busy), 32'd1);
    check("mr_locked", 32'(locked), 32'd0);
    check("mr_wcount", 32'(write_count), 32'd0);
    wait_clear(n_busy);
    check("mr_clear_len", 32'(n_busy), 32'd784);
    rd("mr_rd783", 16'd783, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
